// File: rtl/mux_nx1_stream.sv
// N:1 registered stream multiplexer with valid/ready handshake.
// Each transfer picks one input channel, either by an explicit select or by
// round-robin arbitration. The result lands in a single output register, so
// data appears one cycle after it is accepted. Back-pressure is handled at
// full throughput: a new item can load on the same edge the old one drains.
module mux_nx1_stream #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  // Output register stage and round-robin pointer.
  logic [WIDTH-1:0] data_p0;
  logic [SEL_W-1:0] chan_p0;
  logic             vld_p0;
  logic [SEL_W-1:0] ptr;

  logic                load_en;
  logic [CHANNELS-1:0] grant;
  logic                rr_found;
  logic [SEL_W-1:0]    rr_idx;
  logic [SEL_W-1:0]    chan_sel;
  logic [WIDTH-1:0]    mux_data;
  logic                xfer;

  // Channel reached by stepping j places forward from p, wrapping at CHANNELS.
  function automatic int wrap_add(input logic [SEL_W-1:0] p, input int j);
    int s;
    s = int'(p) + j;
    if (s >= CHANNELS) s = s - CHANNELS;
    return s;
  endfunction

  // The slot can take a new item when it is empty or is being drained now.
  assign load_en = !vld_p0 || out_ready;

  // Round-robin candidate: first valid channel at or after ptr, wrapping.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!rr_found && in_valid[i] && (i == wrap_add(ptr, j))) begin
          rr_found = 1'b1;
          rr_idx   = SEL_W'(i);
        end
      end
    end
  end

  // One-hot grant; mode 0 ignores in_valid so ready never depends on data.
  // An out-of-range select matches no channel, so nothing is granted.
  always_comb begin
    grant = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (mode) grant[i] = rr_found && (int'(rr_idx) == i);
      else      grant[i] = (int'(sel) == i);
    end
  end

  // Nothing is offered while reset is asserted.
  assign in_ready = (reset && load_en) ? grant : '0;
  assign chan_sel = mode ? rr_idx : sel;
  assign xfer     = |(in_valid & in_ready);

  // Data path steered by the one-hot ready vector.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_ready[i]) mux_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // ---- stage p0: output register; pointer advances past the served channel
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      chan_p0 <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      vld_p0  <= 1'b1;
      data_p0 <= mux_data;
      chan_p0 <= chan_sel;
      if (mode) ptr <= (int'(rr_idx) == CHANNELS - 1) ? '0 : rr_idx + 1'b1;
    end else if (out_ready) begin
      vld_p0 <= 1'b0;
    end
  end

  assign out_data  = data_p0;
  assign out_chan  = chan_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Directed bench for mux_nx1_stream: a 4-channel and a 3-channel instance
// driven from hand-computed vectors.
module tb_mux_nx1_stream;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  // 4-channel instance
  logic        mode4;
  logic [1:0]  sel4;
  logic [31:0] in_data4;
  logic [3:0]  in_valid4;
  logic [3:0]  in_ready4;
  logic [7:0]  out_data4;
  logic        out_valid4;
  logic        out_ready4;
  logic [1:0]  out_chan4;

  // 3-channel instance
  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic [1:0]  out_chan3;

  mux_nx1_stream #(.WIDTH(8), .CHANNELS(4)) u_dut4 (
    .clock(clock), .reset(reset), .mode(mode4), .sel(sel4),
    .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out_chan(out_chan4)
  );

  mux_nx1_stream #(.WIDTH(8), .CHANNELS(3)) u_dut3 (
    .clock(clock), .reset(reset), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_chan(out_chan3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int rr4_exp[4] = '{1, 3, 1, 3};
  int rr3_exp[4] = '{0, 1, 2, 0};

  initial begin
    reset      = 1'b0;
    mode4      = 1'b0;
    sel4       = 2'd2;
    in_valid4  = 4'hF;
    out_ready4 = 1'b1;
    in_data4   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    mode3      = 1'b0;
    sel3       = 2'd3;
    in_valid3  = 3'b111;
    out_ready3 = 1'b1;
    in_data3   = {8'hC2, 8'hC1, 8'hC0};
    #2;

    // reset state
    check("rst_valid", out_valid4, 0);
    check("rst_data", out_data4, 0);
    check("rst_chan", out_chan4, 0);
    check("rst_ready", in_ready4, 0);

    tick();
    reset = 1'b1;
    #1;

    // mode 0, sel=2
    check("m0_ready", in_ready4, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("m0_valid", out_valid4, 1);
      check("m0_data", out_data4, 8'hA2);
      check("m0_chan", out_chan4, 2);
      check("m0_ready_run", in_ready4, 4'b0100);
    end

    // asynchronous reset mid-stream
    reset = 1'b0;
    #1;
    check("arst_valid", out_valid4, 0);
    check("arst_data", out_data4, 0);
    check("arst_chan", out_chan4, 0);
    check("arst_ready", in_ready4, 0);
    #1;
    reset = 1'b1;
    tick();
    check("reload_data", out_data4, 8'hA2);
    check("reload_valid", out_valid4, 1);

    // back-pressure: output held while the channel data moves on
    out_ready4 = 1'b0;
    in_data4[23:16] = 8'hB2;
    #1;
    check("bp_ready", in_ready4, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_data", out_data4, 8'hA2);
      check("bp_valid", out_valid4, 1);
      check("bp_chan", out_chan4, 2);
      check("bp_ready_hold", in_ready4, 0);
    end
    out_ready4 = 1'b1;
    #1;
    check("bp_release_ready", in_ready4, 4'b0100);
    tick();
    check("bp_next_data", out_data4, 8'hB2);
    check("bp_next_valid", out_valid4, 1);

    // mode 1, all valid: 0,1,2,3,0,1,2,3 leaves ptr at 0
    mode4 = 1'b1;
    in_data4[23:16] = 8'hA2;
    #1;
    check("rr_ready0", in_ready4, 4'b0001);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr_chan", out_chan4, k % 4);
      check("rr_data", out_data4, 8'hA0 + (k % 4));
      check("rr_valid", out_valid4, 1);
      check("rr_ready", in_ready4, 4'b0001 << ((k + 1) % 4));
    end

    // mode 1, sparse valid: channel 0 skipped after the wrap
    in_valid4 = 4'b1010;
    #1;
    check("rr_sparse_ready0", in_ready4, 4'b0010);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_sparse_chan", out_chan4, rr4_exp[k]);
      check("rr_sparse_data", out_data4, 8'hA0 + rr4_exp[k]);
    end

    // no valid input: slot drains, data and channel keep last value
    in_valid4 = 4'b0000;
    #1;
    check("idle_ready", in_ready4, 0);
    tick();
    check("idle_valid", out_valid4, 0);
    check("idle_data", out_data4, 8'hA3);
    check("idle_chan", out_chan4, 3);

    // 3 channels, out-of-range select
    check("c3_sel3_ready", in_ready3, 0);
    check("c3_sel3_valid", out_valid3, 0);
    mode3 = 1'b1;
    #1;
    check("c3_rr_ready0", in_ready3, 3'b001);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("c3_rr_chan", out_chan3, rr3_exp[k]);
      check("c3_rr_data", out_data3, 8'hC0 + rr3_exp[k]);
      check("c3_rr_valid", out_valid3, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
